start_accept_arbiter: RTL and testbench
=======================================

Name: start_accept_arbiter

Overview:
- Shares one start/accept/cancel transaction channel between NUM_REQ requesters.
- Round-robin grant; issues a 1-cycle start to the shared resource, waits for accept, and aborts with a 1-cycle cancel on timeout or requester withdrawal.
- Guarantees the channel protocol: cancel is never high from start through accept of a completing transaction.

Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- MIN_GAP, 5, cycles after start during which accept is illegal and ignored (1..255)
- TIMEOUT, 64, cycles in WAIT without accept before abort (must be > MIN_GAP, <= 1023)

Ports:
- clk  in  1  clock, all logic on posedge
- rst  in  1  asynchronous reset, active-high
- req  in  NUM_REQ  per-requester transaction request, level
- gnt  out  NUM_REQ  one-hot grant, held from START through DONE/CANCEL
- done  out  NUM_REQ  1-cycle pulse to granted requester on accept
- aborted  out  NUM_REQ  1-cycle pulse to granted requester on abort
- start  out  1  to resource: transaction start, 1-cycle pulse
- cancel  out  1  to resource: abort, 1-cycle pulse
- accept  in  1  from resource: transaction accepted, sampled in WAIT only
- busy  out  1  high in any state other than IDLE
- err_early  out  1  sticky: accept seen inside MIN_GAP window

Behaviour:
- Reset (async assert, sync-effect release): state IDLE, gnt=0, done=0, aborted=0, start=0, cancel=0, busy=0, err_early=0, rr pointer=0, counters=0.
- States: IDLE, START, WAIT, CANCEL, DONE.
- IDLE:
  - If any req bit is set, grant the first set bit at or after the rr pointer (wrapping) and go to START.
  - gnt is registered and asserts in the START cycle.
- START:
  - start=1 for exactly this cycle.
  - Wait counter cleared.
  - Next state WAIT unconditionally; accept is ignored in this cycle.
- WAIT:
  - Counter increments each cycle, saturating at TIMEOUT.
  - Priority, highest first:
    - (a) granted req=0 -> CANCEL;
    - (b) accept=1 with counter >= MIN_GAP-1 (i.e. the accept arrives at least MIN_GAP cycles after start) -> DONE;
    - (c) accept=1 inside the gap -> set err_early, stay in WAIT, accept ignored;
    - (d) counter reaches TIMEOUT -> CANCEL.
- DONE: done[g]=1 for one cycle, gnt cleared, rr pointer = g+1 mod NUM_REQ, -> IDLE.
- CANCEL: cancel=1 and aborted[g]=1 for one cycle, gnt cleared, rr pointer = g+1 mod NUM_REQ, -> IDLE.
- At least one IDLE cycle between transactions; start never asserts on two consecutive cycles.
- cancel is asserted only in the CANCEL state, so it is never high in START or WAIT or on the accepting cycle.
- Simultaneous accept and req drop in WAIT: the abort wins (priority a); accept is discarded.
- Simultaneous accept and timeout: the accept wins when legal (priority b).
- Requests arriving during a transaction are held by the requester (level); no queuing inside the block.
- Reset mid-transaction returns to IDLE immediately with all outputs 0; no cancel is emitted.

Optional Feature:
- Macro: START_ACCEPT_ARBITER_SVA_EN.
- Defined: the block compiles in concurrent assertions on posedge clk, disabled during rst:
  - start implies no legal accept for MIN_GAP cycles (start |-> !accept_legal[*MIN_GAP]);
  - !cancel throughout (start ##1 done_any[->1]) for completing transactions;
  - gnt is one-hot-or-zero;
  - start and cancel are never asserted together.
- Defined: cover properties for start-to-accept with no cancel, timeout abort, withdrawal abort, and rr wrap.
- Undefined: no assertions or covers; RTL behaviour is identical.

Test Plan:
- Single requester, req[0]=1, accept 7 cycles after start -> start 1 cycle, done[0] pulse, cancel never high, err_early=0.
- accept 2 cycles after start, then again at cycle 6 (MIN_GAP=5) -> err_early=1 sticky, first accept ignored, done[0] on second accept.
- No accept -> cancel and aborted[g] pulse exactly TIMEOUT=64 cycles after entering WAIT, then IDLE.
- req=4'b1111 held, accept each time -> grants 0,1,2,3,0 in order, one IDLE cycle between, start never back-to-back.
- req[2] dropped in WAIT in the same cycle as a legal accept -> cancel pulse, aborted[2]=1, done[2]=0.
- rst asserted in WAIT -> all outputs 0 asynchronously; after release, req[1] is granted first with rr pointer=0.

Source files
------------

// File: rtl/start_accept_arbiter.sv
// Round-robin arbiter sharing one start/accept/cancel channel among NUM_REQ requesters.
// Define START_ACCEPT_ARBITER_SVA_EN to compile in protocol assertions and covers.
module start_accept_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int MIN_GAP = 5,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [NUM_REQ-1:0] done,
    output logic [NUM_REQ-1:0] aborted,
    output logic               start,
    output logic               cancel,
    input  logic               accept,
    output logic               busy,
    output logic               err_early
);
    // state    | meaning
    // S_IDLE   | no transaction; arbitrate among req
    // S_START  | start pulse to resource, grant held
    // S_WAIT   | counting toward accept or timeout
    // S_CANCEL | cancel + aborted pulse, release grant
    // S_DONE   | done pulse, release grant

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = 10;
    localparam logic [CW-1:0] GAP_LAST = CW'(MIN_GAP - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] TO_MAX   = CW'(TIMEOUT);
    localparam logic [PW-1:0] IDX_LAST = PW'(NUM_REQ - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_CANCEL, S_DONE} state_t;

    state_t              state, state_next;
    logic [NUM_REQ-1:0]  gnt_q;
    logic [PW-1:0]       gidx, rr, sel, scan;
    logic [CW-1:0]       cnt;
    logic                err_q, found, held, in_gap, acc_legal, acc_early, timed_out;
    int                  idx;

    // Scan downward so the set bit nearest the rr pointer is written last and wins.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        idx   = 0;
        scan  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = int'(rr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            scan = idx[PW-1:0];
            if (req[scan]) begin
                sel   = scan;
                found = 1'b1;
            end
        end
    end

    assign held      = |(req & gnt_q);
    assign in_gap    = (cnt < GAP_LAST);
    assign acc_legal = accept && !in_gap;
    assign acc_early = (state == S_WAIT) && held && accept && in_gap;
    assign timed_out = (cnt == TO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (found) state_next = S_START;
            S_START:  state_next = S_WAIT;
            S_WAIT: begin
                if (!held)          state_next = S_CANCEL;
                else if (acc_legal) state_next = S_DONE;
                else if (timed_out) state_next = S_CANCEL;
            end
            S_CANCEL: state_next = S_IDLE;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_q <= '0;
            gidx  <= '0;
            rr    <= '0;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (found) begin
                        gnt_q <= NUM_REQ'(1) << sel;
                        gidx  <= sel;
                    end
                end
                S_START: cnt <= '0;
                S_WAIT:  if (cnt != TO_MAX) cnt <= cnt + 1'b1;
                S_CANCEL, S_DONE: begin
                    gnt_q <= '0;
                    cnt   <= '0;
                    rr    <= (gidx == IDX_LAST) ? '0 : gidx + 1'b1;
                end
                default: ;
            endcase
            if (acc_early) err_q <= 1'b1;
        end
    end

    assign gnt       = gnt_q;
    assign start     = (state == S_START);
    assign cancel    = (state == S_CANCEL);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE)   ? gnt_q : '0;
    assign aborted   = (state == S_CANCEL) ? gnt_q : '0;
    assign err_early = err_q;

`ifdef START_ACCEPT_ARBITER_SVA_EN
    logic accept_legal, done_any, aborted_any;
    assign accept_legal = (state == S_WAIT) && acc_legal;
    assign done_any     = |done;
    assign aborted_any  = |aborted;

    a_gap: assert property (@(posedge clk) disable iff (rst)
        start |-> !accept_legal [*MIN_GAP]);
    a_no_cancel: assert property (@(posedge clk) disable iff (rst)
        start |=> (!cancel throughout done_any[->1]) or (!done_any throughout aborted_any[->1]));
    a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
    a_excl: assert property (@(posedge clk) disable iff (rst) !(start && cancel));

    c_complete: cover property (@(posedge clk) disable iff (rst)
        start ##1 (!cancel) [*1:$] ##0 done_any);
    c_timeout: cover property (@(posedge clk) disable iff (rst)
        (state == S_WAIT) && held && !acc_legal && timed_out ##1 cancel);
    c_withdraw: cover property (@(posedge clk) disable iff (rst)
        (state == S_WAIT) && !held ##1 cancel);
    c_wrap: cover property (@(posedge clk) disable iff (rst)
        (state == S_DONE || state == S_CANCEL) && gidx == IDX_LAST);
`endif
endmodule

// File: tb/tb_start_accept_arbiter.sv
// Directed bench for start_accept_arbiter: transaction vectors plus reset corner cases.
module tb_start_accept_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = '0;
    logic       accept = 1'b0;
    logic [3:0] gnt, done, aborted;
    logic       start, cancel, busy, err_early;

    int checks = 0;
    int failures = 0;

    start_accept_arbiter #(.NUM_REQ(4), .MIN_GAP(5), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt), .done(done), .aborted(aborted),
        .start(start), .cancel(cancel), .accept(accept), .busy(busy), .err_early(err_early)
    );

    always #5 clk = ~clk;

    // acc/drop are cycle offsets from the start cycle (k=0); -1 means never.
    typedef struct {
        logic [3:0] req;
        int         acc1;
        int         acc2;
        int         drop;
        int         exp_g;
        bit         exp_done;
        int         exp_end;
        bit         exp_err;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int n, input vec_t v);
        int k, endk;
        logic [3:0] g, eg;
        bit got, bad_cancel, bad_start, bad_gnt;
        req = v.req;
        accept = 1'b0;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            step();
            if (start) got = 1;
        end
        chk($sformatf("v%0d_start_seen", n), int'(got), 1);
        if (!got) return;
        g  = gnt;
        eg = 4'b0001 << v.exp_g;
        chk($sformatf("v%0d_gnt", n), int'(gnt), int'(eg));
        chk($sformatf("v%0d_busy", n), int'(busy), 1);
        k = 0;
        endk = -1;
        bad_cancel = 0; bad_start = 0; bad_gnt = 0;
        while (endk < 0 && k < 200) begin
            accept = (k == v.acc1) || (k == v.acc2);
            if (k == v.drop) req = v.req & ~g;
            step();
            k++;
            if (done != 0 || aborted != 0) endk = k;
            else begin
                if (cancel) bad_cancel = 1;
                if (start) bad_start = 1;
                if (gnt != eg) bad_gnt = 1;
            end
        end
        accept = 1'b0;
        chk($sformatf("v%0d_end_cycle", n), endk, v.exp_end);
        chk($sformatf("v%0d_no_early_cancel", n), int'(bad_cancel), 0);
        chk($sformatf("v%0d_single_start", n), int'(bad_start), 0);
        chk($sformatf("v%0d_gnt_held", n), int'(bad_gnt), 0);
        chk($sformatf("v%0d_done", n), int'(done), v.exp_done ? int'(eg) : 0);
        chk($sformatf("v%0d_aborted", n), int'(aborted), v.exp_done ? 0 : int'(eg));
        chk($sformatf("v%0d_cancel", n), int'(cancel), v.exp_done ? 0 : 1);
        chk($sformatf("v%0d_err_early", n), int'(err_early), int'(v.exp_err));
        step();
        chk($sformatf("v%0d_idle_gap", n), int'({busy, start, cancel, gnt}), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        vecs[0] = '{4'b0001,  7, -1, -1, 0, 1,  8, 0};
        vecs[1] = '{4'b1111,  5, -1, -1, 1, 1,  6, 0};
        vecs[2] = '{4'b1111, 64, -1, -1, 2, 1, 65, 0};
        vecs[3] = '{4'b1111,  7, -1, -1, 3, 1,  8, 0};
        vecs[4] = '{4'b1111,  7, -1, -1, 0, 1,  8, 0};
        vecs[5] = '{4'b0100,  3, -1,  3, 2, 0,  4, 0};
        vecs[6] = '{4'b0001, -1, -1, -1, 0, 0, 65, 0};
        vecs[7] = '{4'b1001,  7, -1, -1, 3, 1,  8, 0};
        vecs[8] = '{4'b0001,  2,  6, -1, 0, 1,  7, 1};
        vecs[9] = '{4'b0010,  4,  5, -1, 1, 1,  6, 1};

        repeat (3) @(posedge clk);
        #1;
        req = 4'b1111;
        #1;
        chk("reset_outputs", int'({gnt, done, aborted, start, cancel, busy, err_early}), 0);
        req = '0;
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("idle_after_reset", int'({gnt, start, cancel, busy}), 0);

        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        // reset mid-WAIT: rr was 2, so req 1010 grants 3 before reset and 1 after
        req = 4'b1010;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            step();
            if (start) got = 1;
        end
        chk("rst_pre_gnt", int'(gnt), 4'b1000);
        step(); step(); step();
        chk("rst_pre_busy", int'(busy), 1);
        rst = 1'b1;
        #1;
        chk("rst_async_outputs", int'({gnt, done, aborted, start, cancel, busy, err_early}), 0);
        @(negedge clk);
        rst = 1'b0;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            step();
            if (cancel) chk("rst_no_cancel", int'(cancel), 0);
            if (start) got = 1;
        end
        chk("rst_post_start_seen", int'(got), 1);
        chk("rst_post_gnt_rr0", int'(gnt), 4'b0010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
